// File: rtl/reg_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rwarb_pkg
// Shared types and helpers for the register-file write-port arbiter.
//   rwarb_state_t : arbiter sequencer states (IDLE, CLEAR, DONE)
//   GID_W(n)      : width of a requester index, never less than 1 bit
// ---------------------------------------------------------------------------
package rwarb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } rwarb_state_t;

   // Index width for n requesters; a single-bit index is kept even for n <= 2
   function automatic int GID_W(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: selects the first asserted valid bit at
// or after ptr, wrapping modulo N.
// Ports:
//   valid [N]    request vector
//   ptr   [GW]   starting index (must be < N)
//   grant [N]    one-hot grant (all zero when nothing is valid)
//   index [GW]   index of the granted requester
//   any          at least one requester is valid
// ---------------------------------------------------------------------------
module rr_pick
   import rwarb_pkg::*;
#(
   parameter  int N  = 2,
   localparam int GW = GID_W(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [GW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [GW-1:0] index,
   output logic          any
);

   logic [2*N-1:0] dbl_s;
   logic [2*N-1:0] rot_s;
   logic [GW:0]    sum_s;

   // Rotate the doubled vector so bit 0 is the pointer position, then take
   // the lowest set bit; scanning downward lets the lowest offset win last.
   always_comb begin
      dbl_s = {valid, valid};
      rot_s = dbl_s >> ptr;
      any   = 1'b0;
      sum_s = {(GW+1){1'b0}};
      for (int k = N - 1; k >= 0; k--) begin
         if (rot_s[k]) begin
            any   = 1'b1;
            sum_s = {1'b0, ptr} + (GW+1)'(k);
         end else begin
            sum_s = sum_s;
         end
      end
      if (sum_s >= (GW+1)'(N)) begin
         sum_s = sum_s - (GW+1)'(N);
      end else begin
         sum_s = sum_s;
      end
      index = sum_s[GW-1:0];
      if (any) begin
         grant = {{(N-1){1'b0}}, 1'b1} << index;
      end else begin
         grant = {N{1'b0}};
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
// Shares the single write port of a 2**D x W register file (address 0 is
// hardwired to zero) among N valid/ready requesters with round-robin grants,
// and provides a clear sequencer that writes 0 to registers 1..2**D-1.
// Optional build macro: RWARB_COLLIDE_EN adds a sticky collide_err output.
// Ports:
//   CLK, RST_N        clock; synchronous active-low reset
//   req_valid  [N]    requester has a write pending
//   req_ready  [N]    one-hot grant (combinational, 0 while RST_N=0)
//   req_addr   [N*D]  per-requester destination address
//   req_data   [N*W]  per-requester write data
//   clear_req         start clear sequence (honoured in IDLE only)
//   clear_busy        clear sequence running
//   clear_done        one-cycle pulse after the last clear write
//   rf_write_en, rf_waddr, rf_data_in   registered register-file write port
//   grant_id   [GW]   requester whose write is on rf_*; holds when idle
//   collide_err       (RWARB_COLLIDE_EN) equal nonzero addresses seen
// ---------------------------------------------------------------------------
module reg_write_arbiter
   import rwarb_pkg::*;
#(
   parameter  int W  = 8,
   parameter  int D  = 4,
   parameter  int N  = 2,
   localparam int GW = GID_W(N)
) (
   input  logic           CLK,
   input  logic           RST_N,
   input  logic [N-1:0]   req_valid,
   output logic [N-1:0]   req_ready,
   input  logic [N*D-1:0] req_addr,
   input  logic [N*W-1:0] req_data,
   input  logic           clear_req,
   output logic           clear_busy,
   output logic           clear_done,
   output logic           rf_write_en,
   output logic [D-1:0]   rf_waddr,
   output logic [W-1:0]   rf_data_in,
   output logic [GW-1:0]  grant_id
`ifdef RWARB_COLLIDE_EN
   ,
   output logic           collide_err
`endif
);

   localparam logic [D-1:0] CNT_LAST = {D{1'b1}};

   rwarb_state_t  state_r;
   rwarb_state_t  state_next_s;
   logic [D-1:0]  cnt_r;
   logic [GW-1:0] ptr_r;
   logic [GW-1:0] ptr_next_s;
   logic          clear_busy_r;
   logic          clear_done_r;
   logic          rf_write_en_r;
   logic [D-1:0]  rf_waddr_r;
   logic [W-1:0]  rf_data_in_r;
   logic [GW-1:0] grant_id_r;

   logic [N-1:0]  pick_grant_s;
   logic [GW-1:0] pick_idx_s;
   logic          pick_any_s;
   logic          accept_s;
   logic [D-1:0]  sel_addr_s;
   logic [W-1:0]  sel_data_s;

   rr_pick #(.N(N)) u_pick (
      .valid (req_valid),
      .ptr   (ptr_r),
      .grant (pick_grant_s),
      .index (pick_idx_s),
      .any   (pick_any_s)
   );

   // Handshake qualification, grant fan-out and winner payload mux
   always_comb begin
      accept_s   = RST_N && (state_r == IDLE) && !clear_req && pick_any_s;
      sel_addr_s = {D{1'b0}};
      sel_data_s = {W{1'b0}};
      if (accept_s) begin
         req_ready = pick_grant_s;
      end else begin
         req_ready = {N{1'b0}};
      end
      for (int i = 0; i < N; i++) begin
         if (pick_idx_s == GW'(i)) begin
            sel_addr_s = req_addr[i*D +: D];
            sel_data_s = req_data[i*W +: W];
         end else begin
            sel_addr_s = sel_addr_s;
         end
      end
      if (pick_idx_s == GW'(N - 1)) begin
         ptr_next_s = {GW{1'b0}};
      end else begin
         ptr_next_s = pick_idx_s + GW'(1'b1);
      end
   end

   // Sequencer next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (clear_req) begin
               state_next_s = CLEAR;
            end else begin
               state_next_s = IDLE;
            end
         end
         CLEAR: begin
            if (cnt_r == CNT_LAST) begin
               state_next_s = DONE;
            end else begin
               state_next_s = CLEAR;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Sequencer state plus status flags registered from the next state
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_r      <= IDLE;
         clear_busy_r <= 1'b0;
         clear_done_r <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         clear_busy_r <= (state_next_s == CLEAR);
         clear_done_r <= (state_next_s == DONE);
      end
   end

   // Write-port registers, clear counter and round-robin pointer.
   // rf_waddr tracks cnt_r exactly during CLEAR, so both load together.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt_r         <= {D{1'b0}};
         ptr_r         <= {GW{1'b0}};
         rf_write_en_r <= 1'b0;
         rf_waddr_r    <= {D{1'b0}};
         rf_data_in_r  <= {W{1'b0}};
         grant_id_r    <= {GW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (clear_req) begin
                  cnt_r         <= D'(1'b1);
                  rf_write_en_r <= 1'b1;
                  rf_waddr_r    <= D'(1'b1);
                  rf_data_in_r  <= {W{1'b0}};
               end else if (accept_s) begin
                  // Address 0 is consumed but never written
                  rf_write_en_r <= (sel_addr_s != {D{1'b0}});
                  rf_waddr_r    <= sel_addr_s;
                  rf_data_in_r  <= sel_data_s;
                  ptr_r         <= ptr_next_s;
                  if (sel_addr_s != {D{1'b0}}) begin
                     grant_id_r <= pick_idx_s;
                  end else begin
                     grant_id_r <= grant_id_r;
                  end
               end else begin
                  rf_write_en_r <= 1'b0;
               end
            end
            CLEAR: begin
               if (cnt_r == CNT_LAST) begin
                  rf_write_en_r <= 1'b0;
               end else begin
                  cnt_r         <= cnt_r + D'(1'b1);
                  rf_write_en_r <= 1'b1;
                  rf_waddr_r    <= cnt_r + D'(1'b1);
                  rf_data_in_r  <= {W{1'b0}};
               end
            end
            DONE:    rf_write_en_r <= 1'b0;
            default: rf_write_en_r <= 1'b0;
         endcase
      end
   end

`ifdef RWARB_COLLIDE_EN
   logic collide_hit_s;
   logic collide_err_r;

   // Any pair of valid requesters targeting the same nonzero address
   always_comb begin
      collide_hit_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = i + 1; j < N; j++) begin
            if (req_valid[i] && req_valid[j] &&
                (req_addr[i*D +: D] == req_addr[j*D +: D]) &&
                (req_addr[i*D +: D] != {D{1'b0}})) begin
               collide_hit_s = 1'b1;
            end else begin
               collide_hit_s = collide_hit_s;
            end
         end
      end
   end

   // Sticky collision flag; entering CLEAR wipes it
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         collide_err_r <= 1'b0;
      end else if (state_r == IDLE && clear_req) begin
         collide_err_r <= 1'b0;
      end else if (state_r == IDLE && collide_hit_s) begin
         collide_err_r <= 1'b1;
      end else begin
         collide_err_r <= collide_err_r;
      end
   end

   assign collide_err = collide_err_r;
`endif

   assign clear_busy  = clear_busy_r;
   assign clear_done  = clear_done_r;
   assign rf_write_en = rf_write_en_r;
   assign rf_waddr    = rf_waddr_r;
   assign rf_data_in  = rf_data_in_r;
   assign grant_id    = grant_id_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
// Directed scenarios with literal expectations followed by randomized
// traffic, all compared every cycle against a queue-based behavioural model.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int N  = 2;
   localparam int GW = 1;

   logic           CLK = 1'b0;
   logic           RST_N;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*D-1:0] req_addr;
   logic [N*W-1:0] req_data;
   logic           clear_req;
   logic           clear_busy;
   logic           clear_done;
   logic           rf_write_en;
   logic [D-1:0]   rf_waddr;
   logic [W-1:0]   rf_data_in;
   logic [GW-1:0]  grant_id;
`ifdef RWARB_COLLIDE_EN
   logic           collide_err;
`endif

   always #5 CLK = ~CLK;

   reg_write_arbiter #(.W(W), .D(D), .N(N)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .clear_req   (clear_req),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .rf_write_en (rf_write_en),
      .rf_waddr    (rf_waddr),
      .rf_data_in  (rf_data_in),
      .grant_id    (grant_id)
`ifdef RWARB_COLLIDE_EN
      ,
      .collide_err (collide_err)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int             m_phase;          // 0 idle, 1 clearing, 2 done pulse
   int             m_ptr;
   logic           m_we;
   logic [D-1:0]   m_waddr;
   logic [W-1:0]   m_data;
   int             m_gid;
   logic           m_coll;
   logic [D-1:0]   clr_q[$];
   logic [N-1:0]   last_acc;
   bit             chk_en = 1'b0;

   function automatic int pick_first(input logic [N-1:0] v, input int p);
      logic [N-1:0] t;
      for (int k = 0; k < N; k++) begin
         t = v >> ((p + k) % N);
         if (t[0]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [D-1:0] addr_of(input int i);
      logic [N*D-1:0] t;
      t = req_addr >> (i * D);
      return t[D-1:0];
   endfunction

   function automatic logic [W-1:0] data_of(input int i);
      logic [N*W-1:0] t;
      t = req_data >> (i * W);
      return t[W-1:0];
   endfunction

   function automatic logic [N-1:0] exp_ready();
      int w;
      if (!RST_N || m_phase != 0 || clear_req) return '0;
      w = pick_first(req_valid, m_ptr);
      if (w < 0) return '0;
      return N'(1) << w;
   endfunction

   always @(posedge CLK) begin
      int w;
      last_acc = '0;
      if (!RST_N) begin
         m_phase = 0; m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_data = '0;
         m_gid = 0; m_coll = 1'b0; clr_q.delete();
      end else if (m_phase == 0) begin
         if (clear_req) begin
            clr_q.delete();
            for (int a = 1; a < (1 << D); a++) clr_q.push_back(D'(a));
            m_waddr = clr_q.pop_front(); m_we = 1'b1; m_data = '0;
            m_phase = 1; m_coll = 1'b0;
         end else begin
            for (int i = 0; i < N; i++)
               for (int j = i + 1; j < N; j++)
                  if (((req_valid >> i) & 1) != 0 && ((req_valid >> j) & 1) != 0 &&
                      addr_of(i) == addr_of(j) && addr_of(i) != 0)
                     m_coll = 1'b1;
            w = pick_first(req_valid, m_ptr);
            if (w >= 0) begin
               last_acc = N'(1) << w;
               m_waddr = addr_of(w); m_data = data_of(w);
               m_we = (m_waddr != 0);
               if (m_waddr != 0) m_gid = w;
               m_ptr = (w + 1) % N;
            end else begin
               m_we = 1'b0;
            end
         end
      end else if (m_phase == 1) begin
         if (clr_q.size() > 0) begin
            m_waddr = clr_q.pop_front(); m_we = 1'b1; m_data = '0;
         end else begin
            m_we = 1'b0; m_phase = 2;
         end
      end else begin
         m_we = 1'b0; m_phase = 0;
      end
   end

   // Single compare process: every cycle, mid-period
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("m_ready", 32'(req_ready), 32'(exp_ready()));
         chk("m_we", 32'(rf_write_en), 32'(m_we));
         chk("m_waddr", 32'(rf_waddr), 32'(m_waddr));
         chk("m_data", 32'(rf_data_in), 32'(m_data));
         chk("m_gid", 32'(grant_id), 32'(m_gid));
         chk("m_busy", 32'(clear_busy), 32'(m_phase == 1));
         chk("m_done", 32'(clear_done), 32'(m_phase == 2));
`ifdef RWARB_COLLIDE_EN
         chk("m_coll", 32'(collide_err), 32'(m_coll));
`endif
      end
   end

   // Shadow register file fed from the DUT write port (register 0 hardwired)
   logic [W-1:0] shadow [1 << D];
   bit           sh_preset;
   always @(posedge CLK) begin
      if (sh_preset) begin
         for (int i = 0; i < (1 << D); i++) shadow[i] <= 8'hA5;
      end else if (rf_write_en && rf_waddr != 0) begin
         shadow[rf_waddr] <= rf_data_in;
      end
   end

   task automatic set_req(input int i, input logic v, input logic [D-1:0] a, input logic [W-1:0] d);
      req_valid[i]      = v;
      req_addr[i*D +: D] = a;
      req_data[i*W +: W] = d;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      RST_N = 1'b0; clear_req = 1'b0; sh_preset = 1'b1;
      req_valid = '0; req_addr = '0; req_data = '0;
      set_req(0, 1'b1, 4'd3, 8'hAA);
      set_req(1, 1'b1, 4'd5, 8'h55);

      // Reset held two cycles with both requesters valid
      @(posedge CLK); #2; chk_en = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         chk("rst_ready", 32'(req_ready), 32'h0);
         chk("rst_we", 32'(rf_write_en), 32'h0);
         chk("rst_busy", 32'(clear_busy), 32'h0);
      end
      #1 RST_N = 1'b1; sh_preset = 1'b0;

      // Round-robin alternation, write port one cycle behind the grant
      for (int k = 0; k < 4; k++) begin
         #1 chk("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
         @(negedge CLK);
         chk("rr_we", 32'(rf_write_en), 32'h1);
         chk("rr_waddr", 32'(rf_waddr), (k % 2 == 0) ? 32'h3 : 32'h5);
         chk("rr_data", 32'(rf_data_in), (k % 2 == 0) ? 32'hAA : 32'h55);
         chk("rr_gid", 32'(grant_id), 32'(k % 2));
      end

      // Address 0: accepted, not written, payload still visible
      req_valid = '0;
      set_req(0, 1'b1, 4'd0, 8'hFF);
      #1 chk("a0_ready", 32'(req_ready), 32'h1);
      @(negedge CLK);
      chk("a0_we", 32'(rf_write_en), 32'h0);
      chk("a0_waddr", 32'(rf_waddr), 32'h0);
      chk("a0_data", 32'(rf_data_in), 32'hFF);
      chk("a0_gid", 32'(grant_id), 32'h1);
      chk("sh3", 32'(shadow[3]), 32'hAA);
      chk("sh5", 32'(shadow[5]), 32'h55);
      req_valid = '0;

      // Clear sequence with a competing request
      set_req(0, 1'b1, 4'd2, 8'h11);
      clear_req = 1'b1;
      #1 chk("clr_ready0", 32'(req_ready), 32'h0);
      @(posedge CLK); #2 clear_req = 1'b0;
      for (int k = 1; k < 16; k++) begin
         @(negedge CLK);
         chk("clr_we", 32'(rf_write_en), 32'h1);
         chk("clr_waddr", 32'(rf_waddr), 32'(k));
         chk("clr_data", 32'(rf_data_in), 32'h0);
         chk("clr_ready", 32'(req_ready), 32'h0);
         chk("clr_busy", 32'(clear_busy), 32'h1);
      end
      @(negedge CLK);
      chk("done_pulse", 32'(clear_done), 32'h1);
      chk("done_we", 32'(rf_write_en), 32'h0);
      chk("done_ready", 32'(req_ready), 32'h0);
      for (int i = 1; i < 16; i++) chk("sh_zero", 32'(shadow[i]), 32'h0);
      @(negedge CLK);
      chk("post_ready", 32'(req_ready), 32'h1);
      chk("post_done", 32'(clear_done), 32'h0);
      @(posedge CLK); #2 req_valid = '0;

      // Reset in the fifth CLEAR cycle
      clear_req = 1'b1;
      @(posedge CLK); #2 clear_req = 1'b0;
      for (int k = 1; k < 6; k++) begin
         @(negedge CLK);
         chk("mid_waddr", 32'(rf_waddr), 32'(k));
      end
      #1 RST_N = 1'b0;
      @(negedge CLK);
      chk("mid_busy", 32'(clear_busy), 32'h0);
      chk("mid_done", 32'(clear_done), 32'h0);
      chk("mid_we", 32'(rf_write_en), 32'h0);
      #1 RST_N = 1'b1;
      @(negedge CLK);
      chk("mid_done2", 32'(clear_done), 32'h0);
      chk("mid_busy2", 32'(clear_busy), 32'h0);

`ifdef RWARB_COLLIDE_EN
      #1;
      set_req(0, 1'b1, 4'd7, 8'h01);
      set_req(1, 1'b1, 4'd7, 8'h02);
      @(negedge CLK);
      chk("coll_set", 32'(collide_err), 32'h1);
      #1 req_valid = '0;
      repeat (2) @(negedge CLK);
      chk("coll_hold", 32'(collide_err), 32'h1);
      #1 clear_req = 1'b1;
      @(negedge CLK);
      chk("coll_clr", 32'(collide_err), 32'h0);
      @(posedge CLK); #2 clear_req = 1'b0;
      repeat (17) @(posedge CLK);
      #2;
`else
      @(posedge CLK); #2;
`endif

      // Randomized traffic; a pending requester keeps its payload
      for (int cyc = 0; cyc < 3000; cyc++) begin
         RST_N     = ($urandom_range(0, 199) != 0);
         clear_req = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < N; i++) begin
            if (((req_valid >> i) & 1) != 0 && ((last_acc >> i) & 1) == 0) begin
               set_req(i, 1'b1, addr_of(i), data_of(i));
            end else begin
               set_req(i, ($urandom_range(0, 99) < 70),
                       ($urandom_range(0, 1) != 0) ? D'($urandom_range(0, 3)) : D'($urandom_range(0, 15)),
                       W'($urandom));
            end
         end
         @(posedge CLK); #2;
      end

      RST_N = 1'b1; clear_req = 1'b0; req_valid = '0;
      repeat (20) @(posedge CLK);
      @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
